ibex_instr_sram_adapter: RTL and testbench

- Sits directly upstream of ibex_prefetch_buffer, between the core instruction port (req/gnt/rvalid protocol) and a single-port instruction SRAM.
- Grants fetch requests subject to SRAM arbitration and an outstanding-request cap, and issues word reads to the SRAM.
- Returns data in order with fixed latency.
- Out-of-range fetches are answered in order with an error response and never reach the SRAM. The first faulting address is captured for debug.

---
 rtl/ibex_instr_sram_adapter.sv | 117 +++++++++++
 tb/tb_ibex_instr_sram_adapter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_sram_adapter.sv
// Instruction-side adapter between the Ibex prefetch buffer (req/gnt/rvalid) and a
// single-port SRAM: range check, outstanding cap, fixed-latency in-order responses.
module ibex_instr_sram_adapter #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter logic [31:0] MemSize        = 32'h0001_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ErrData        = 32'h0000_0000,
    localparam int unsigned AW            = $clog2(MemSize / 4)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    output logic          sram_req_o,
    input  logic          sram_gnt_i,
    output logic [AW-1:0] sram_addr_o,
    input  logic [31:0]   sram_rdata_i,
    output logic          err_valid_o,
    output logic [31:0]   err_addr_o,
    input  logic          err_clear_i,
    output logic          busy_o
);

    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
        $error("ReadLatency must be in 1..4");
    end
    if (MemSize < 8 || (MemSize & (MemSize - 32'd1)) != 32'd0) begin : g_bad_size
        $error("MemSize must be a power of two and at least 8");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > ReadLatency + 1) begin : g_bad_outstanding
        $error("MaxOutstanding must be in 1..ReadLatency+1");
    end

    logic [31:0]            off;
    logic                   in_range;
    logic                   slot_ok;
    logic [CW-1:0]          cnt_q;
    logic [ReadLatency-1:0] vld_q;
    logic [ReadLatency-1:0] err_q;
    logic [29:0]            eaddr_q [ReadLatency];
    logic                   err_valid_q;
    logic [29:0]            err_addr_q;

    // Wrapping subtraction lets addresses below MemBase fall out of range naturally.
    assign off      = instr_addr_i - MemBase;
    assign in_range = off < MemSize;
    assign slot_ok  = (cnt_q < MaxCnt) | instr_rvalid_o;

    assign sram_req_o  = instr_req_i & in_range & slot_ok;
    assign instr_gnt_o = instr_req_i & slot_ok & (in_range ? sram_gnt_i : 1'b1);
    assign sram_addr_o = off[AW+1:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < ReadLatency; i++) begin
                eaddr_q[i] <= '0;
            end
        end else begin
            vld_q[0]   <= instr_gnt_o;
            err_q[0]   <= instr_gnt_o & ~in_range;
            eaddr_q[0] <= (instr_gnt_o & ~in_range) ? instr_addr_i[31:2] : 30'd0;
            for (int i = 1; i < ReadLatency; i++) begin
                vld_q[i]   <= vld_q[i-1];
                err_q[i]   <= err_q[i-1];
                eaddr_q[i] <= eaddr_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = vld_q[ReadLatency-1];
    assign instr_err_o    = vld_q[ReadLatency-1] & err_q[ReadLatency-1];
    assign instr_rdata_o  = !instr_rvalid_o ? 32'd0 :
                            instr_err_o     ? ErrData : sram_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (instr_gnt_o && !instr_rvalid_o) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (!instr_gnt_o && instr_rvalid_o) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy_o = (cnt_q != '0);

    // Clear has priority, so an error retiring in the clear cycle is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_clear_i) begin
            err_valid_q <= 1'b0;
        end else if (instr_err_o && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= eaddr_q[ReadLatency-1];
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = {err_addr_q, 2'b00};

    a_cnt_cap : assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt);
    a_cnt_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_o && !instr_gnt_o && cnt_q == '0));

endmodule

// File: tb/tb_ibex_instr_sram_adapter.sv
// Bench for ibex_instr_sram_adapter: behavioural SRAM, per-cycle response scoreboard,
// and directed scenario tasks with their own checks.
module tb_ibex_instr_sram_adapter;

    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0001_0000;
    localparam int          RL       = 2;
    localparam int          MO       = 2;
    localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

    logic        clk;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        sram_req_o;
    logic        sram_gnt_i;
    logic [13:0] sram_addr_o;
    logic [31:0] sram_rdata_i;
    logic        err_valid_o;
    logic [31:0] err_addr_o;
    logic        err_clear_i;
    logic        busy_o;

    int vecs = 0;
    int miscmp = 0;
    int cyc = 0;

    ibex_instr_sram_adapter #(
        .MemBase(MEM_BASE), .MemSize(MEM_SIZE), .ReadLatency(RL),
        .MaxOutstanding(MO), .ErrData(ERR_DATA)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .sram_req_o(sram_req_o), .sram_gnt_i(sram_gnt_i),
        .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
        .err_clear_i(err_clear_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [13:0] w);
        return {2'b10, w, 2'b01, ~w};
    endfunction

    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (sram_req_o && sram_gnt_i) ? mem_word(sram_addr_o) : 32'hDEAD_BEEF;
    end
    assign sram_rdata_i = rd_pipe[RL-1];

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_off;
    logic        m_inr, m_rv, m_slot, m_gnt, m_sreq;
    int          m_cnt;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst_ni) begin
            sb.delete();
            vecs++;
            if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
                miscmp++;
                $display("FAIL sb_reset_quiet: rvalid=%b busy=%b, required 0 0", instr_rvalid_o, busy_o);
            end
        end else begin
            m_off  = instr_addr_i - MEM_BASE;
            m_inr  = m_off < MEM_SIZE;
            m_cnt  = sb.size();
            m_rv   = (m_cnt > 0) && (sb[0].due == cyc);
            m_slot = (m_cnt < MO) || m_rv;
            m_gnt  = instr_req_i && m_slot && (m_inr ? sram_gnt_i : 1'b1);
            m_sreq = instr_req_i && m_inr && m_slot;
            vecs++;
            if (instr_rvalid_o !== m_rv) begin
                miscmp++;
                $display("FAIL sb_rvalid @%0d: got %b, required %b", cyc, instr_rvalid_o, m_rv);
            end
            if (m_rv) begin
                m_e = sb.pop_front();
                vecs++;
                if (instr_err_o !== m_e.err || instr_rdata_o !== m_e.data) begin
                    miscmp++;
                    $display("FAIL sb_resp @%0d: got err=%b data=%h, required err=%b data=%h",
                             cyc, instr_err_o, instr_rdata_o, m_e.err, m_e.data);
                end
            end else begin
                vecs++;
                if (instr_rdata_o !== 32'd0 || instr_err_o !== 1'b0) begin
                    miscmp++;
                    $display("FAIL sb_idle @%0d: got err=%b data=%h, required 0 0", cyc, instr_err_o, instr_rdata_o);
                end
            end
            vecs++;
            if (instr_gnt_o !== m_gnt || sram_req_o !== m_sreq || busy_o !== (m_cnt != 0)) begin
                miscmp++;
                $display("FAIL sb_handshake @%0d: got gnt=%b sreq=%b busy=%b, required %b %b %b",
                         cyc, instr_gnt_o, sram_req_o, busy_o, m_gnt, m_sreq, m_cnt != 0);
            end
            if (m_sreq) begin
                vecs++;
                if (sram_addr_o !== m_off[15:2]) begin
                    miscmp++;
                    $display("FAIL sb_sram_addr @%0d: got %h, required %h", cyc, sram_addr_o, m_off[15:2]);
                end
            end
            if (m_gnt) sb.push_back('{cyc + RL, ~m_inr, m_inr ? mem_word(m_off[15:2]) : ERR_DATA});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        instr_req_i  = 1'b1;
        instr_addr_i = a;
        tick();
        instr_req_i  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if (instr_gnt_o !== 1'b0 || instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'd0 ||
            instr_err_o !== 1'b0 || sram_req_o !== 1'b0 || busy_o !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_bus: gnt=%b rv=%b rdata=%h err=%b sreq=%b busy=%b, required all 0",
                     instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, sram_req_o, busy_o);
        end
        vecs++;
        if (err_valid_o !== 1'b0 || err_addr_o !== 32'd0) begin
            miscmp++;
            $display("FAIL reset_err: valid=%b addr=%h, required 0 0", err_valid_o, err_addr_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch(input logic [31:0] a);
        sram_gnt_i   = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = a;
        @(negedge clk);
        vecs++;
        if (instr_gnt_o !== 1'b1 || sram_req_o !== 1'b1 || sram_addr_o !== a[15:2]) begin
            miscmp++;
            $display("FAIL fetch_issue %h: gnt=%b sreq=%b saddr=%h, required 1 1 %h",
                     a, instr_gnt_o, sram_req_o, sram_addr_o, a[15:2]);
        end
        tick();
        instr_req_i = 1'b0;
        repeat (RL - 1) tick();
        @(negedge clk);
        vecs++;
        if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0 || instr_rdata_o !== mem_word(a[15:2])) begin
            miscmp++;
            $display("FAIL fetch_resp %h: rv=%b err=%b data=%h, required 1 0 %h",
                     a, instr_rvalid_o, instr_err_o, instr_rdata_o, mem_word(a[15:2]));
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        sram_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h1000 + 32'(4 * i);
            @(negedge clk);
            vecs++;
            if (instr_gnt_o !== 1'b1) begin
                miscmp++;
                $display("FAIL b2b_gnt cycle %0d: got %b, required 1", i, instr_gnt_o);
            end
            tick();
        end
        instr_req_i = 1'b0;
        repeat (RL + 2) tick();
    endtask

    task automatic test_sram_stall();
        sram_gnt_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (sram_req_o !== 1'b1 || instr_gnt_o !== 1'b0 || busy_o !== 1'b0) begin
                miscmp++;
                $display("FAIL stall cycle %0d: sreq=%b gnt=%b busy=%b, required 1 0 0",
                         i, sram_req_o, instr_gnt_o, busy_o);
            end
            tick();
        end
        sram_gnt_i = 1'b1;
        @(negedge clk);
        vecs++;
        if (instr_gnt_o !== 1'b1) begin
            miscmp++;
            $display("FAIL stall_release_gnt: got %b, required 1", instr_gnt_o);
        end
        tick();
        instr_req_i = 1'b0;
        repeat (RL - 1) tick();
        @(negedge clk);
        vecs++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== mem_word(14'h80)) begin
            miscmp++;
            $display("FAIL stall_resp: rv=%b data=%h, required 1 %h", instr_rvalid_o, instr_rdata_o, mem_word(14'h80));
        end
        repeat (RL + 2) tick();
    endtask

    task automatic test_err_order();
        logic [31:0] seq [3];
        seq = '{32'h0, 32'h0002_0000, 32'h4};
        sram_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_req_i  = 1'b1;
            instr_addr_i = seq[i];
            @(negedge clk);
            vecs++;
            if (instr_gnt_o !== 1'b1 || sram_req_o !== (i != 1)) begin
                miscmp++;
                $display("FAIL err_order_issue %0d: gnt=%b sreq=%b, required 1 %b", i, instr_gnt_o, sram_req_o, i != 1);
            end
            tick();
        end
        instr_req_i = 1'b0;
        repeat (RL + 1) tick();
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0002_0000) begin
            miscmp++;
            $display("FAIL err_order_capture: valid=%b addr=%h, required 1 00020000", err_valid_o, err_addr_o);
        end
        tick();
    endtask

    task automatic test_capture_clear();
        sram_gnt_i = 1'b1;
        issue(32'hFFFF_FFF0);
        repeat (RL + 1) tick();
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0002_0000) begin
            miscmp++;
            $display("FAIL capture_no_overwrite: valid=%b addr=%h, required 1 00020000", err_valid_o, err_addr_o);
        end
        tick();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b0 || err_addr_o !== 32'h0002_0000) begin
            miscmp++;
            $display("FAIL clear: valid=%b addr=%h, required 0 00020000", err_valid_o, err_addr_o);
        end
        tick();
        issue(32'h0003_0000);
        repeat (RL + 1) tick();
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0003_0000) begin
            miscmp++;
            $display("FAIL recapture: valid=%b addr=%h, required 1 00030000", err_valid_o, err_addr_o);
        end
        tick();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        issue(32'h0004_0000);
        repeat (RL - 1) tick();
        err_clear_i = 1'b1;
        @(negedge clk);
        vecs++;
        if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1) begin
            miscmp++;
            $display("FAIL coincide_setup: rv=%b err=%b, required 1 1", instr_rvalid_o, instr_err_o);
        end
        tick();
        err_clear_i = 1'b0;
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b0 || err_addr_o !== 32'h0003_0000) begin
            miscmp++;
            $display("FAIL coincide_clear_wins: valid=%b addr=%h, required 0 00030000", err_valid_o, err_addr_o);
        end
        tick();
        issue(32'h0005_0000);
        repeat (RL + 1) tick();
        @(negedge clk);
        vecs++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0005_0000) begin
            miscmp++;
            $display("FAIL capture_before_reset: valid=%b addr=%h, required 1 00050000", err_valid_o, err_addr_o);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        sram_gnt_i   = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h10;
        @(negedge clk);
        vecs++;
        if (instr_gnt_o !== 1'b1) begin
            miscmp++;
            $display("FAIL midflight_gnt0: got %b, required 1", instr_gnt_o);
        end
        tick();
        instr_addr_i = 32'h14;
        @(negedge clk);
        vecs++;
        if (instr_gnt_o !== 1'b1) begin
            miscmp++;
            $display("FAIL midflight_gnt1: got %b, required 1", instr_gnt_o);
        end
        tick();
        instr_req_i = 1'b0;
        rst_ni      = 1'b0;
        @(negedge clk);
        vecs++;
        if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0 || err_valid_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            miscmp++;
            $display("FAIL midflight_reset: rv=%b busy=%b errv=%b gnt=%b, required all 0",
                     instr_rvalid_o, busy_o, err_valid_o, instr_gnt_o);
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            vecs++;
            if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
                miscmp++;
                $display("FAIL midflight_dropped %0d: rv=%b busy=%b, required 0 0", i, instr_rvalid_o, busy_o);
            end
            tick();
        end
        test_single_fetch(32'h8);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            instr_req_i = 1'($urandom_range(0, 1));
            sram_gnt_i  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       instr_addr_i = 32'h0002_0000 + ($urandom & 32'hFFFF);
                1:       instr_addr_i = 32'hFFFF_FFFC;
                default: instr_addr_i = $urandom & 32'hFFFF;
            endcase
            tick();
        end
        instr_req_i = 1'b0;
        sram_gnt_i  = 1'b1;
        repeat (RL + 2) tick();
    endtask

    initial begin
        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'd0;
        sram_gnt_i   = 1'b0;
        err_clear_i  = 1'b0;
        test_reset();
        test_single_fetch(32'h100);
        test_back_to_back();
        test_sram_stall();
        test_err_order();
        test_capture_clear();
        test_reset_midflight();
        test_random();
        vecs++;
        if (sb.size() != 0) begin
            miscmp++;
            $display("FAIL drain: %0d responses still pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
